rr_resource_arbiter: RTL and testbench
======================================

Name: rr_resource_arbiter

Overview:
- Sits directly downstream of N pipeline_top instances.
- Arbitrates their arbiter_req lines round-robin and drives each instance's arbiter_grant.
- Muxes the granted instance's resource_input onto a single shared fixed-latency resource.
- Tags each issue and, RES_LAT cycles later, returns the resource result to the originating instance's resource_output with a one-hot valid.

Parameters:
NUM_REQ, 4, number of requesting pipelines (2..8)
DATA_W, 32, data width of request and response
RES_LAT, 2, fixed latency of shared resource in cycles (1..8)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-pipeline arbiter_req
req_data  in  NUM_REQ*DATA_W  per-pipeline resource_input; slice i = bits [i*DATA_W +: DATA_W]
flush  in  NUM_REQ  per-pipeline flush; kills that pipeline's in-flight results
grant  out  NUM_REQ  one-hot arbiter_grant to each pipeline
res_issue_data  out  DATA_W  operand to shared resource
res_issue_valid  out  1  operand valid this cycle
res_result  in  DATA_W  shared resource output, valid exactly RES_LAT cycles after issue
rsp_data  out  DATA_W  resource result broadcast to all pipelines
rsp_valid  out  NUM_REQ  one-hot: which pipeline owns rsp_data this cycle
busy  out  1  any tag in flight

Behaviour:
- State:
  - ptr: log2(NUM_REQ) bits, index of highest-priority requester.
  - Tag pipeline: RES_LAT stages, each {valid, id}.
- Grant (combinational from req and registered ptr):
  - Scan from ptr upward with wrap-around.
  - Grant the first i with req[i]=1. At most one grant bit set.
  - grant=0 when req=0.
  - grant=0 while reset=1.
- Issue:
  - res_issue_valid = |grant.
  - res_issue_data = req_data slice of granted index, else 0.
  - Issue accepted the same cycle grant is high; no ready from resource.
- Pointer update at edge:
  - If any grant, ptr <= granted index + 1 (mod NUM_REQ).
  - Otherwise ptr is held.
  - A single persistent requester with no competitors is granted every cycle.
- Tag pipeline:
  - Stage0 <= {|grant, granted index}.
  - Stage k <= stage k-1 each cycle.
  - The last stage aligns with res_result.
- Response:
  - rsp_valid[id] = 1 when last stage is valid.
  - rsp_data = res_result when valid, else 0.
  - Latency from grant cycle to rsp_valid = RES_LAT cycles.
- Flush: in any cycle flush[i]=1:
  - Clear valid on every tag stage holding id i, including the tag being written to stage0 this cycle.
  - grant[i] is forced 0 that cycle and arbitration skips i.
  - Response for i suppressed in the same cycle if last stage holds i.
  - Other ids unaffected.
- busy = OR of all stage valids.
- Reset (synchronous) effects:
  - ptr=0.
  - All tag valids=0.
  - Outputs: grant=0, res_issue_valid=0, rsp_valid=0, rsp_data=0, busy=0.
  - Reset mid-operation discards in-flight tags; results arriving afterwards are dropped.
- Simultaneous events:
  - req and flush on the same index: flush wins.
  - Issue and response in the same cycle are independent; full throughput is one issue and one response per cycle.
- Invariants (checked by assertion):
  - grant one-hot or zero.
  - rsp_valid one-hot or zero.
  - grant[i] implies req[i].

Test Plan:
- Reset, then req=4'b0001, req_data[0]=0x11, res_result echoes issue delayed by 2 -> grant=0001 each cycle; rsp_valid=0001 with rsp_data=0x11 exactly 2 cycles after each grant.
- req=4'b1111 held 8 cycles from ptr=0 -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000; rsp_valid follows the same sequence 2 cycles later.
- req=4'b1010 with ptr=2 -> grant=1000, then 0010, then 1000; ptr wraps 3->0 correctly.
- Grant pipeline 1 at cycle t, assert flush=0010 at t+1 -> no rsp_valid[1] at t+2; pipeline 3 granted at t+1 still receives rsp_valid=1000 at t+3.
- req=0101 with flush=0001 the same cycle -> grant=0100 only; ptr advances to 3.
- Three back-to-back grants, then reset asserted for one cycle -> busy=0 and rsp_valid=0 for the following RES_LAT cycles; ptr=0, so next req=1111 grants 0001.

Source files
------------

// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin sharing of one fixed-latency resource among NUM_REQ pipelines
// with tagged, flushable result return.
module rr_resource_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int RES_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        flush,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         res_issue_data,
  output logic                      res_issue_valid,
  input  logic [DATA_W-1:0]         res_result,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      busy
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr, gid;
  logic any, last;
  logic [NUM_REQ-1:0] elig;
  logic [RES_LAT-1:0] tv;
  logic [IW-1:0] tid [RES_LAT];
  assign elig = reset ? '0 : req & ~flush;
  // Descending scan so the requester closest to ptr (in wrap order) is written last and wins.
  always_comb begin
    gid = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig[(int'(ptr) + k) % NUM_REQ]) begin
        gid = IW'((int'(ptr) + k) % NUM_REQ);
        any = 1'b1;
      end
  end
  assign grant = any ? NUM_REQ'(1) << gid : '0;
  assign res_issue_valid = any;
  assign res_issue_data = any ? req_data[int'(gid)*DATA_W +: DATA_W] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      tv <= '0;
    end else begin
      if (any) ptr <= IW'((int'(gid) + 1) % NUM_REQ);
      tv[0] <= any;
      for (int k = 1; k < RES_LAT; k++) tv[k] <= tv[k-1] & ~flush[tid[k-1]];
    end
  end
  always_ff @(posedge clk) begin
    tid[0] <= gid;
    for (int k = 1; k < RES_LAT; k++) tid[k] <= tid[k-1];
  end
  assign last = tv[RES_LAT-1] & ~flush[tid[RES_LAT-1]] & ~reset;
  assign rsp_valid = last ? NUM_REQ'(1) << tid[RES_LAT-1] : '0;
  assign rsp_data = last ? res_result : '0;
  assign busy = |tv & ~reset;
  assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant) && $onehot0(rsp_valid) && ((grant & ~req) == '0));
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb_rr_resource_arbiter: directed plus random stimulus against a queue-based model of
// round-robin issue and RES_LAT-delayed, flush-killable responses.
module tb_rr_resource_arbiter;
  localparam int N = 4, DW = 32, RL = 2;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0, flush = '0, grant, rsp_valid;
  logic [N*DW-1:0] req_data = '0;
  logic [DW-1:0] res_issue_data, res_result = '0, rsp_data;
  logic res_issue_valid, busy;
  int nvec = 0, nerr = 0, cyc = 0, mptr = 0;
  typedef struct {int id; int due; logic [DW-1:0] d; bit alive;} ent_t;
  ent_t pend[$];
  logic [DW-1:0] hist [RL];

  rr_resource_arbiter #(.NUM_REQ(N), .DATA_W(DW), .RES_LAT(RL)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .flush(flush),
    .grant(grant), .res_issue_data(res_issue_data), .res_issue_valid(res_issue_valid),
    .res_result(res_result), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, a, e);
    end
  endtask

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  // lg/lr: literal expected grant / rsp_valid, or -1 when the cycle has no hand-computed value
  task automatic step(input bit rs, input logic [N-1:0] r, input logic [N-1:0] f,
                      input logic [N*DW-1:0] d, input int lg, input int lr);
    logic [N-1:0] eg, erv;
    logic [DW-1:0] erd, eid;
    bit eb;
    int gi;
    @(negedge clk);
    reset = rs; req = r; flush = f; req_data = d; res_result = hist[RL-1];
    #1;
    eb = 0; eg = '0; erv = '0; erd = '0; eid = '0; gi = -1;
    foreach (pend[i]) if (pend[i].alive) eb = 1;
    if (rs) eb = 0;
    else begin
      foreach (pend[i]) if (f[pend[i].id]) pend[i].alive = 0;
      foreach (pend[i])
        if (pend[i].due == cyc && pend[i].alive) begin
          erv[pend[i].id] = 1'b1;
          erd = pend[i].d;
        end
      for (int k = 0; k < N; k++)
        if (gi < 0 && r[(mptr + k) % N] && !f[(mptr + k) % N]) gi = (mptr + k) % N;
      if (gi >= 0) begin
        eg[gi] = 1'b1;
        eid = d[gi*DW +: DW];
      end
    end
    chk("grant", grant, eg);
    chk("issue_valid", res_issue_valid, gi >= 0);
    chk("issue_data", res_issue_data, eid);
    chk("rsp_valid", rsp_valid, erv);
    chk("rsp_data", rsp_data, erd);
    chk("busy", busy, eb);
    if (lg >= 0) chk("lit_grant", grant, lg);
    if (lr >= 0) chk("lit_rsp_valid", rsp_valid, lr);
    for (int k = RL - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = res_issue_valid ? res_issue_data : $urandom;
    @(posedge clk);
    if (rs) begin
      pend.delete();
      mptr = 0;
    end else begin
      if (gi >= 0) begin
        pend.push_back('{gi, cyc + RL, d[gi*DW +: DW], 1'b1});
        mptr = (gi + 1) % N;
      end
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    end
    cyc++;
  endtask

  initial begin
    logic [N*DW-1:0] d11;
    logic [N-1:0] rr, ff;
    for (int k = 0; k < RL; k++) hist[k] = '0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    d11 = rnd_data();
    d11[DW-1:0] = 32'h11;
    step(0, 4'b0001, 0, d11, 1, 0);
    step(0, 4'b0001, 0, d11, 1, 0);
    step(0, 4'b0001, 0, d11, 1, 1);
    step(0, 4'b0001, 0, d11, 1, 1);
    step(0, 0, 0, d11, 0, 1);
    step(0, 0, 0, d11, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Full contention from ptr=0
    step(0, 4'b1111, 0, rnd_data(), 1, 0);
    step(0, 4'b1111, 0, rnd_data(), 2, 0);
    step(0, 4'b1111, 0, rnd_data(), 4, 1);
    step(0, 4'b1111, 0, rnd_data(), 8, 2);
    step(0, 4'b1111, 0, rnd_data(), 1, 4);
    step(0, 4'b1111, 0, rnd_data(), 2, 8);
    step(0, 4'b1111, 0, rnd_data(), 4, 1);
    step(0, 4'b1111, 0, rnd_data(), 8, 2);
    step(0, 0, 0, 0, 0, 4);
    step(0, 0, 0, 0, 0, 8);
    // Wrap 3->0 starting from ptr=2
    step(0, 4'b0010, 0, rnd_data(), 2, 0);
    step(0, 4'b1010, 0, rnd_data(), 8, 0);
    step(0, 4'b1010, 0, rnd_data(), 2, 2);
    step(0, 4'b1010, 0, rnd_data(), 8, 8);
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 8);
    // Flush kills id 1 in flight, id 3 survives
    step(0, 4'b0010, 0, rnd_data(), 2, 0);
    step(0, 4'b1000, 4'b0010, rnd_data(), 8, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8);
    // Flush beats req on the same index
    step(0, 4'b0101, 4'b0001, rnd_data(), 4, 0);
    step(0, 4'b1111, 0, rnd_data(), 8, 0);
    step(0, 0, 0, 0, 0, 4);
    step(0, 0, 0, 0, 0, 8);
    // Reset mid-flight discards tags
    step(0, 4'b1111, 0, rnd_data(), 1, 0);
    step(0, 4'b1111, 0, rnd_data(), 2, 0);
    step(0, 4'b1111, 0, rnd_data(), 4, 1);
    step(1, 4'b1111, 0, rnd_data(), 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 4'b1111, 0, rnd_data(), 1, 0);
    for (int i = 0; i < 3000; i++) begin
      rr = N'($urandom);
      ff = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      step($urandom_range(0, 99) == 0, rr, ff, rnd_data(), -1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
